// File: rtl/frame_update_scheduler_pkg.sv
// frame_update_scheduler_pkg: shared key codes, FSM/command enums, playfield defaults and spawn helpers
package frame_update_scheduler_pkg;
    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ROT   = 8'h75;
    localparam int SPAWN_Y   = 0;
    localparam int SPAWN_ROT = 0;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_QUERY, S_COMMIT, S_LOCK} state_t;
    typedef enum logic [2:0] {C_LEFT, C_RIGHT, C_DOWN, C_ROT, C_GRAV} cmd_t;
    function automatic int spawn_x(input int cols);
        return cols / 2 - 1;
    endfunction
    function automatic logic is_fall(input cmd_t c);
        return c == C_DOWN || c == C_GRAV;
    endfunction
endpackage

// File: rtl/frame_update_scheduler_if.sv
// frame_update_scheduler_if: collision-query handshake between the scheduler and the playfield checker
// Signals: oQ_REQ request, oQ_X/oQ_Y/oQ_ROT candidate, iQ_ACK answer strobe, iQ_BLOCKED collision result
interface frame_update_scheduler_if;
    logic       oQ_REQ;
    logic [3:0] oQ_X;
    logic [4:0] oQ_Y;
    logic [1:0] oQ_ROT;
    logic       iQ_ACK;
    logic       iQ_BLOCKED;
    modport master (output oQ_REQ, oQ_X, oQ_Y, oQ_ROT, input iQ_ACK, iQ_BLOCKED);
    modport slave  (input oQ_REQ, oQ_X, oQ_Y, oQ_ROT, output iQ_ACK, iQ_BLOCKED);
endinterface

// File: rtl/frame_update_scheduler_gravity_timer.sv
// gravity_timer: counts frame starts and pulses due_o every GRAV_FRAMES frames
// Ports: iVGA_CLK clock, iRST_n async active-low reset, frame_i frame strobe,
//   clear_i restart count (wins over frame_i), due_o one-cycle wrap pulse
module gravity_timer #(
    parameter int GRAV_FRAMES = 30
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic frame_i,
    input  logic clear_i,
    output logic due_o
);
    localparam int W = $clog2(GRAV_FRAMES + 1);
    localparam logic [W-1:0] LAST = W'(GRAV_FRAMES - 1);
    logic [W-1:0] cnt_q, cnt_d;
    logic wrap;
    always_comb begin
        wrap  = cnt_q == LAST;
        cnt_d = clear_i ? '0 : !frame_i ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        due_o = frame_i & ~clear_i & wrap;
    end
    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: once per frame, serves one key and one gravity step through collision queries
// Ports: iVGA_CLK/iRST_n clock and async active-low reset; iVS active-low vsync;
//   iKEY_VALID/iKEY_CODE key strobe and PS/2 make code; query collision-query master;
//   oPIECE_X/Y/ROT committed piece; oLOCK landed pulse; oBUSY scheduler not idle
module frame_update_scheduler
    import frame_update_scheduler_pkg::*;
#(
    parameter int GRAV_FRAMES = 30,
    parameter int COLS        = COLS_DEF,
    parameter int ROWS        = ROWS_DEF
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic       iKEY_VALID,
    input  logic [7:0] iKEY_CODE,
    frame_update_scheduler_if.master query,
    output logic [3:0] oPIECE_X,
    output logic [4:0] oPIECE_Y,
    output logic [1:0] oPIECE_ROT,
    output logic       oLOCK,
    output logic       oBUSY
);
    localparam logic [3:0] X_MAX   = 4'(COLS - 1);
    localparam logic [4:0] Y_MAX   = 5'(ROWS - 1);
    localparam logic [3:0] X_SPAWN = 4'(spawn_x(COLS));
    state_t state_q, state_d;
    cmd_t key_cmd_q, key_cmd_d, cmd_q, cmd_d, sel, key_new;
    logic vs_q, frame_start, key_hit, grav_tick, serve_key, serve_grav, serve, at_edge, ack_ok;
    logic key_v_q, key_v_d, grav_due_q, grav_due_d, frame_pend_q, frame_pend_d;
    logic key_done_q, key_done_d, grav_done_q, grav_done_d;
    logic [3:0] px_q, px_d, cx_q, cx_d;
    logic [4:0] py_q, py_d, cy_q, cy_d;
    logic [1:0] pr_q, pr_d, cr_q, cr_d;

    gravity_timer #(.GRAV_FRAMES(GRAV_FRAMES)) u_grav (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .frame_i  (frame_start),
        .clear_i  (state_q == S_LOCK),
        .due_o    (grav_tick)
    );

    // Key and gravity each get at most one service per pass; the done flags reset in IDLE.
    always_comb begin
        frame_start = vs_q & ~iVS;
        key_hit     = iKEY_VALID & (iKEY_CODE inside {KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_ROT});
        key_new     = iKEY_CODE == KEY_LEFT ? C_LEFT : iKEY_CODE == KEY_RIGHT ? C_RIGHT :
                      iKEY_CODE == KEY_DOWN ? C_DOWN : C_ROT;
        serve_key   = (state_q == S_ARB) & key_v_q & ~key_done_q;
        serve_grav  = (state_q == S_ARB) & ~serve_key & grav_due_q & ~grav_done_q;
        serve       = serve_key | serve_grav;
        sel         = serve_key ? key_cmd_q : C_GRAV;
        at_edge     = (sel == C_LEFT && px_q == '0) || (sel == C_RIGHT && px_q == X_MAX) ||
                      (is_fall(sel) && py_q == Y_MAX);
        ack_ok      = (state_q == S_QUERY) & query.iQ_ACK & ~query.iQ_BLOCKED;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) state_q <= S_IDLE;
        else         state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (frame_start | frame_pend_q) ? S_ARB : S_IDLE;
            S_ARB:    state_d = !serve ? S_IDLE : !at_edge ? S_QUERY : is_fall(sel) ? S_LOCK : S_ARB;
            S_QUERY:  state_d = !query.iQ_ACK ? S_QUERY : !query.iQ_BLOCKED ? S_COMMIT :
                                is_fall(cmd_q) ? S_LOCK : S_ARB;
            S_COMMIT: state_d = S_ARB;
            S_LOCK:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A fresh key wins over consumption/discard so a same-cycle arrival stays pending.
    always_comb begin
        frame_pend_d = (state_q != S_IDLE) & (frame_pend_q | frame_start);
        key_done_d   = (state_q != S_IDLE) & (key_done_q | serve_key);
        grav_done_d  = (state_q != S_IDLE) & (grav_done_q | serve_grav);
        key_v_d      = key_hit | (key_v_q & ~serve_key & (state_q != S_LOCK));
        key_cmd_d    = key_hit ? key_new : key_cmd_q;
        grav_due_d   = grav_tick | (grav_due_q & ~serve_grav & (state_q != S_LOCK));
        cmd_d        = serve ? sel : cmd_q;
        cx_d         = !serve ? cx_q : sel == C_LEFT ? px_q - 4'd1 : sel == C_RIGHT ? px_q + 4'd1 : px_q;
        cy_d         = !serve ? cy_q : is_fall(sel) ? py_q + 5'd1 : py_q;
        cr_d         = !serve ? cr_q : sel == C_ROT ? pr_q + 2'd1 : pr_q;
        px_d         = state_q == S_LOCK ? X_SPAWN : ack_ok ? cx_q : px_q;
        py_d         = state_q == S_LOCK ? 5'(SPAWN_Y) : ack_ok ? cy_q : py_q;
        pr_d         = state_q == S_LOCK ? 2'(SPAWN_ROT) : ack_ok ? cr_q : pr_q;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n)
        if (!iRST_n) begin
            vs_q         <= 1'b1;
            frame_pend_q <= 1'b0;
            key_done_q   <= 1'b0;
            grav_done_q  <= 1'b0;
            key_v_q      <= 1'b0;
            key_cmd_q    <= C_LEFT;
            grav_due_q   <= 1'b0;
            cmd_q        <= C_LEFT;
            cx_q         <= '0;
            cy_q         <= '0;
            cr_q         <= '0;
            px_q         <= X_SPAWN;
            py_q         <= 5'(SPAWN_Y);
            pr_q         <= 2'(SPAWN_ROT);
        end else begin
            vs_q         <= iVS;
            frame_pend_q <= frame_pend_d;
            key_done_q   <= key_done_d;
            grav_done_q  <= grav_done_d;
            key_v_q      <= key_v_d;
            key_cmd_q    <= key_cmd_d;
            grav_due_q   <= grav_due_d;
            cmd_q        <= cmd_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            cr_q         <= cr_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pr_q         <= pr_d;
        end

    always_comb begin
        query.oQ_REQ = state_q == S_QUERY;
        query.oQ_X   = state_q == S_QUERY ? cx_q : '0;
        query.oQ_Y   = state_q == S_QUERY ? cy_q : '0;
        query.oQ_ROT = state_q == S_QUERY ? cr_q : '0;
        oLOCK        = state_q == S_LOCK;
        oBUSY        = state_q != S_IDLE;
        oPIECE_X     = px_q;
        oPIECE_Y     = py_q;
        oPIECE_ROT   = pr_q;
    end
endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb_frame_update_scheduler: directed checks of frame scheduling, moves, edges, locking and reset
module tb_frame_update_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, vs, kv;
    logic [7:0] kc;
    logic [3:0] px, lx;
    logic [4:0] py, ly;
    logic [1:0] pr, lr;
    logic       lock, busy;
    int         tests = 0, fails = 0, nq, nl;

    frame_update_scheduler_if q ();

    frame_update_scheduler #(.GRAV_FRAMES(2)) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .iVS        (vs),
        .iKEY_VALID (kv),
        .iKEY_CODE  (kc),
        .query      (q),
        .oPIECE_X   (px),
        .oPIECE_Y   (py),
        .oPIECE_ROT (pr),
        .oLOCK      (lock),
        .oBUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0; vs = 1'b1; kv = 1'b0; kc = 8'h00; q.iQ_ACK = 1'b0; q.iQ_BLOCKED = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] c);
        kv = 1'b1; kc = c;
        @(negedge clk);
        kv = 1'b0;
    endtask

    task automatic vs_pulse;
        vs = 1'b0;
        @(negedge clk);
        vs = 1'b1;
    endtask

    // Answers every query with blk until the scheduler has been idle for two cycles.
    task automatic serve(input logic blk);
        int idle;
        idle = 0; nq = 0; nl = 0;
        for (int i = 0; i < 100 && idle < 2; i++) begin
            @(negedge clk);
            if (q.oQ_REQ) begin
                nq++; lx = q.oQ_X; ly = q.oQ_Y; lr = q.oQ_ROT;
                q.iQ_ACK = 1'b1; q.iQ_BLOCKED = blk;
                @(negedge clk);
                q.iQ_ACK = 1'b0; q.iQ_BLOCKED = 1'b0;
            end
            nl += int'(lock);
            idle = busy ? 0 : idle + 1;
        end
        if (idle < 2) begin tests++; fails++; $display("FAIL serve_timeout: scheduler still busy"); end
    endtask

    task automatic frame(input logic [7:0] c, input logic blk);
        if (c != 8'h00) send_key(c);
        vs_pulse();
        serve(blk);
    endtask

    task automatic wait_req;
        for (int i = 0; i < 6 && !q.oQ_REQ; i++) @(negedge clk);
        tests++;
        if (q.oQ_REQ !== 1'b1) begin fails++; $display("FAIL wait_req: got req=%b want 1", q.oQ_REQ); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vs = 1'b1; kv = 1'b0; kc = 8'h00; q.iQ_ACK = 1'b0; q.iQ_BLOCKED = 1'b0;
        @(negedge clk);
        tests++;
        if ({q.oQ_REQ, lock, busy} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b want 000", {q.oQ_REQ, lock, busy}); end
        tests++;
        if ({px, py, pr} !== {4'd4, 5'd0, 2'd0}) begin fails++; $display("FAIL reset_piece: got %h want %h", {px, py, pr}, {4'd4, 5'd0, 2'd0}); end
        tests++;
        if ({q.oQ_X, q.oQ_Y, q.oQ_ROT} !== 11'd0) begin fails++; $display("FAIL reset_query: got %h want 0", {q.oQ_X, q.oQ_Y, q.oQ_ROT}); end
        rst_n = 1'b1;
        @(negedge clk);
        frame(8'h1C, 1'b0);
        tests++;
        if (nq !== 0 || px !== 4'd4) begin fails++; $display("FAIL ignored_key: got nq=%0d x=%0d want 0 4", nq, px); end
    endtask

    task automatic test_gravity;
        do_reset();
        frame(8'h00, 1'b0);
        tests++;
        if (py !== 5'd0) begin fails++; $display("FAIL grav_f1: got y=%0d want 0", py); end
        frame(8'h00, 1'b0);
        tests++;
        if (py !== 5'd1 || nq !== 1) begin fails++; $display("FAIL grav_f2: got y=%0d nq=%0d want 1 1", py, nq); end
        frame(8'h00, 1'b0);
        tests++;
        if (py !== 5'd1) begin fails++; $display("FAIL grav_f3: got y=%0d want 1", py); end
        frame(8'h00, 1'b0);
        tests++;
        if (py !== 5'd2 || nl !== 0) begin fails++; $display("FAIL grav_f4: got y=%0d lock=%0d want 2 0", py, nl); end
    endtask

    task automatic test_left;
        do_reset();
        send_key(8'h6B);
        vs_pulse();
        wait_req();
        tests++;
        if ({q.oQ_X, q.oQ_Y, q.oQ_ROT} !== {4'd3, 5'd0, 2'd0}) begin fails++; $display("FAIL left_cand: got %h want %h", {q.oQ_X, q.oQ_Y, q.oQ_ROT}, {4'd3, 5'd0, 2'd0}); end
        repeat (3) @(negedge clk);
        tests++;
        if (q.oQ_REQ !== 1'b1 || q.oQ_X !== 4'd3) begin fails++; $display("FAIL left_hold: got req=%b x=%0d want 1 3", q.oQ_REQ, q.oQ_X); end
        q.iQ_ACK = 1'b1;
        @(negedge clk);
        q.iQ_ACK = 1'b0;
        tests++;
        if (px !== 4'd3 || q.oQ_REQ !== 1'b0) begin fails++; $display("FAIL left_commit: got x=%0d req=%b want 3 0", px, q.oQ_REQ); end
        serve(1'b0);
        q.iQ_ACK = 1'b1;
        @(negedge clk);
        q.iQ_ACK = 1'b0;
        @(negedge clk);
        tests++;
        if (px !== 4'd3 || busy !== 1'b0 || nq !== 0) begin fails++; $display("FAIL stray_ack: got x=%0d busy=%b nq=%0d want 3 0 0", px, busy, nq); end
    endtask

    task automatic test_blocked;
        do_reset();
        frame(8'h6B, 1'b1);
        tests++;
        if (nq !== 1 || nl !== 0 || px !== 4'd4) begin fails++; $display("FAIL left_blocked: got nq=%0d lock=%0d x=%0d want 1 0 4", nq, nl, px); end
    endtask

    task automatic test_edges;
        do_reset();
        repeat (4) frame(8'h6B, 1'b0);
        tests++;
        if (px !== 4'd0 || py !== 5'd2) begin fails++; $display("FAIL left_walk: got x=%0d y=%0d want 0 2", px, py); end
        frame(8'h6B, 1'b0);
        tests++;
        if (nq !== 0 || px !== 4'd0) begin fails++; $display("FAIL left_wall: got nq=%0d x=%0d want 0 0", nq, px); end
        repeat (3) frame(8'h75, 1'b0);
        tests++;
        if (pr !== 2'd3 || py !== 5'd4) begin fails++; $display("FAIL rot_walk: got rot=%0d y=%0d want 3 4", pr, py); end
        frame(8'h75, 1'b0);
        tests++;
        if (lr !== 2'd0 || pr !== 2'd0 || nq !== 1) begin fails++; $display("FAIL rot_wrap: got qrot=%0d rot=%0d nq=%0d want 0 0 1", lr, pr, nq); end
        do_reset();
        repeat (5) frame(8'h74, 1'b0);
        tests++;
        if (px !== 4'd9) begin fails++; $display("FAIL right_walk: got x=%0d want 9", px); end
        frame(8'h74, 1'b0);
        tests++;
        if (nq !== 1 || px !== 4'd9 || ly !== 5'd3) begin fails++; $display("FAIL right_wall: got nq=%0d x=%0d qy=%0d want 1 9 3", nq, px, ly); end
    endtask

    task automatic test_lock;
        do_reset();
        frame(8'h6B, 1'b0);
        repeat (10) frame(8'h00, 1'b0);
        tests++;
        if (px !== 4'd3 || py !== 5'd5) begin fails++; $display("FAIL lock_setup: got x=%0d y=%0d want 3 5", px, py); end
        vs_pulse();
        wait_req();
        tests++;
        if (q.oQ_Y !== 5'd6) begin fails++; $display("FAIL lock_cand: got qy=%0d want 6", q.oQ_Y); end
        q.iQ_ACK = 1'b1; q.iQ_BLOCKED = 1'b1;
        @(negedge clk);
        q.iQ_ACK = 1'b0; q.iQ_BLOCKED = 1'b0;
        tests++;
        if (lock !== 1'b1) begin fails++; $display("FAIL lock_pulse: got %b want 1", lock); end
        @(negedge clk);
        tests++;
        if ({lock, busy} !== 2'b00 || {px, py, pr} !== {4'd4, 5'd0, 2'd0}) begin fails++; $display("FAIL lock_spawn: got lock=%b busy=%b piece=%h want 0 0 %h", lock, busy, {px, py, pr}, {4'd4, 5'd0, 2'd0}); end
    endtask

    task automatic test_bottom;
        do_reset();
        repeat (13) frame(8'h72, 1'b0);
        tests++;
        if (py !== 5'd19) begin fails++; $display("FAIL down_walk: got y=%0d want 19", py); end
        frame(8'h72, 1'b0);
        tests++;
        if (nq !== 0 || nl !== 1 || py !== 5'd0) begin fails++; $display("FAIL floor_lock: got nq=%0d lock=%0d y=%0d want 0 1 0", nq, nl, py); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        send_key(8'h6B);
        send_key(8'h74);
        vs_pulse();
        wait_req();
        tests++;
        if (q.oQ_X !== 4'd5) begin fails++; $display("FAIL newest_key: got qx=%0d want 5", q.oQ_X); end
        vs = 1'b0; kv = 1'b1; kc = 8'h6B;
        @(negedge clk);
        vs = 1'b1; kv = 1'b0;
        q.iQ_ACK = 1'b1;
        @(negedge clk);
        q.iQ_ACK = 1'b0;
        tests++;
        if (px !== 4'd5) begin fails++; $display("FAIL right_commit: got x=%0d want 5", px); end
        serve(1'b0);
        tests++;
        if (nq !== 2 || px !== 4'd4 || py !== 5'd1) begin fails++; $display("FAIL second_pass: got nq=%0d x=%0d y=%0d want 2 4 1", nq, px, py); end
    endtask

    task automatic test_reset_mid_query;
        do_reset();
        send_key(8'h6B);
        vs_pulse();
        wait_req();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({q.oQ_REQ, busy} !== 2'b00 || q.oQ_X !== 4'd0) begin fails++; $display("FAIL rst_abort: got req=%b busy=%b qx=%0d want 0 0 0", q.oQ_REQ, busy, q.oQ_X); end
        q.iQ_ACK = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q.iQ_ACK = 1'b0;
        @(negedge clk);
        tests++;
        if (px !== 4'd4 || busy !== 1'b0) begin fails++; $display("FAIL rst_late_ack: got x=%0d busy=%b want 4 0", px, busy); end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_left();
        test_blocked();
        test_edges();
        test_lock();
        test_bottom();
        test_back_to_back();
        test_reset_mid_query();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 SHALL have parameter GRAV_FRAMES, default 30, meaning frames per gravity step (>=1).
REQ-002 SHALL have parameter COLS, default 10, meaning playfield columns; parameter ROWS, default 20, meaning playfield rows.
REQ-003 SHALL have port iVGA_CLK  in  1  pixel clock; all logic rises on it.
REQ-004 SHALL have port iRST_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iVS  in  1  vertical sync from the sync generator, active-low, synchronous to iVGA_CLK.
REQ-006 SHALL have ports iKEY_VALID  in  1  one-cycle key strobe; iKEY_CODE  in  8  PS/2 make code.
REQ-007 SHALL have ports oQ_REQ  out  1  collision query request; oQ_X  out  4; oQ_Y  out  5; oQ_ROT  out  2  candidate position and rotation.
REQ-008 SHALL have ports iQ_ACK  in  1  query answer strobe; iQ_BLOCKED  in  1  candidate collides, valid with iQ_ACK.
REQ-009 SHALL have ports oPIECE_X  out  4; oPIECE_Y  out  5; oPIECE_ROT  out  2  committed piece state for the renderer.
REQ-010 SHALL have ports oLOCK  out  1  one-cycle pulse, piece landed; oBUSY  out  1  FSM not IDLE.

Function
REQ-011 Frame start SHALL be a registered 1->0 transition of iVS; one frame start per frame.
REQ-012 Key capture: codes 8'h6B LEFT, 8'h74 RIGHT, 8'h72 DOWN, 8'h75 ROTATE stored in a one-entry pending slot on iKEY_VALID; other codes ignored; newest valid key overwrites an unserved one.
REQ-013 Key arriving in the same cycle the slot is consumed SHALL remain pending.
REQ-014 Gravity counter SHALL increment per frame start, wrap GRAV_FRAMES-1 -> 0, and set grav_due on wrap; grav_due cleared when gravity is serviced.
REQ-015 FSM states: IDLE, ARB, QUERY, COMMIT, LOCK.
REQ-016 IDLE -> ARB on frame start (or a latched frame_pending); frame start while not IDLE sets frame_pending (one deep, extras dropped).
REQ-017 ARB serves one command per pass, priority: pending key > grav_due; none -> IDLE.
REQ-018 Candidate: LEFT x-1, RIGHT x+1, DOWN/gravity y+1, ROTATE rot+1 mod 4 (2-bit wrap).
REQ-019 LEFT at x=0, RIGHT at x=COLS-1, DOWN/gravity at y=ROWS-1 SHALL NOT query; LEFT/RIGHT discarded -> ARB; DOWN/gravity -> LOCK.
REQ-020 QUERY: oQ_REQ asserted cycle after ARB, held with stable oQ_X/Y/ROT until iQ_ACK; no timeout.
REQ-021 iQ_ACK with iQ_BLOCKED=0 -> COMMIT: oPIECE_* equal candidate on the next cycle, then ARB.
REQ-022 Blocked LEFT/RIGHT/ROTATE -> ARB, state unchanged; blocked DOWN/gravity -> LOCK.
REQ-023 LOCK: oLOCK high one cycle; piece set to spawn x=COLS/2-1, y=0, rot=0; gravity counter and grav_due cleared; pending key discarded; -> IDLE.
REQ-024 At most two commands (one key, one gravity) per frame start; ARB after the second pass returns IDLE.
REQ-025 oQ_REQ low outside QUERY; iQ_ACK outside QUERY ignored.

Reset
REQ-026 iRST_n low SHALL immediately force IDLE, oQ_REQ=0, oLOCK=0, oBUSY=0, oQ_*=0, oPIECE_X=COLS/2-1, oPIECE_Y=0, oPIECE_ROT=0, counter/flags/slot cleared, iVS edge register=1.
REQ-027 Reset mid-QUERY SHALL abandon the query; no commit after release.

Structure
REQ-028 Shared package SHALL hold key-code constants, state enum, spawn coordinates, COLS/ROWS defaults.
REQ-029 Gravity counter SHALL be sub-module gravity_timer (frame strobe in, due pulse out, clear in).

Verification
REQ-030 Reset release, no keys, GRAV_FRAMES=2, always-ack unblocked -> oPIECE_Y 0->1 after 2nd frame start, ->2 after 4th.
REQ-031 Key 8'h6B at x=4 before frame start, ack unblocked -> oQ_X=3 during QUERY, oPIECE_X=3 the cycle after ack.
REQ-032 Key 8'h6B at x=0 -> no oQ_REQ, oPIECE_X stays 0; 8'h75 at rot=3 -> oQ_ROT=0.
REQ-033 Gravity at y=5 answered iQ_BLOCKED=1 -> oLOCK one cycle, piece 4/0/0 next.
REQ-034 Keys 8'h6B then 8'h74 within one frame -> only RIGHT queried; frame start during QUERY -> second pass served after return to IDLE.
REQ-035 iRST_n low while oQ_REQ=1 -> oQ_REQ=0 immediately, late iQ_ACK ignored, piece at spawn.
